// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, default parameters and the round-robin pick
// function used by the FIFO write arbiter and its round-robin selector.
//   state_t    : arbiter FSM states (IDLE, BURST)
//   rr_pick_t  : result of a round-robin search (valid flag + index)
//   rr_pick()  : first set request bit at or after a pointer, wrapping at nreq
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int NREQ_DEF      = 4;
    localparam int DW_DEF        = 8;
    localparam int MAX_BURST_DEF = 4;
    localparam int CW_DEF        = 16;

    // Widest requester vector the pick function handles.
    localparam int RR_MAX = 8;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
    } rr_pick_t;

    // Walk offsets from the far end back to 0 so the smallest offset from
    // rr_ptr is the last one written and therefore wins. The wrap is an
    // explicit subtract of nreq so non-power-of-two counts stay in range.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        rr_ptr,
                                         input int                nreq);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            if (k < nreq) begin
                idx = int'(rr_ptr) + k;
                if (idx >= nreq) idx = idx - nreq;
                if (req[idx]) begin
                    r.vld = 1'b1;
                    r.idx = 3'(idx);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// rr_select: combinational round-robin selector. Finds the first set bit of
// req at or after ptr, wrapping modulo N.
//   req : N-bit request vector
//   ptr : search start index
//   idx : selected index (valid only when vld=1)
//   vld : at least one request is set
module rr_select
    import fifo_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          vld
);

    rr_pick_t pick;

    assign pick = rr_pick(RR_MAX'(req), 3'(ptr), N);
    assign vld  = pick.vld;
    assign idx  = PW'(pick.idx);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NREQ
// requesters. A winner owns the port for a burst of up to MAX_BURST words;
// FIFO full stalls the burst without losing the grant.
//   wrclk    : write-domain clock
//   rst      : synchronous active-high reset
//   req      : per-requester write request (held until acked)
//   req_data : packed requester data, slice i = [i*DW +: DW]
//   full     : FIFO full flag
//   ack      : one-hot, word from requester i accepted this cycle
//   grant    : registered one-hot owner, 0 when idle
//   wrreq    : FIFO write strobe (= |ack)
//   data_in  : FIFO write data (owner's slice)
//   busy     : registered, high while in BURST
//   word_cnt : registered accepted-word count, wraps
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic               wrclk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               full,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    grant,
    output logic               wrreq,
    output logic [DW-1:0]      data_in,
    output logic               busy,
    output logic [CW-1:0]      word_cnt
);

    localparam int PW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [PW-1:0] LAST_REQ  = PW'(NREQ - 1);

    state_t        state, state_nxt;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] sel_idx;
    logic          sel_vld;
    logic [BW-1:0] beat_cnt;
    logic          last;

    rr_select #(.N(NREQ)) u_sel (
        .req (req),
        .ptr (rr_ptr),
        .idx (sel_idx),
        .vld (sel_vld)
    );

    // rst gates ack so a word presented in the reset cycle is never written.
    always_comb begin
        ack = '0;
        if (state == BURST && !rst && !full && req[owner])
            ack[owner] = 1'b1;
    end

    assign wrreq   = |ack;
    assign data_in = req_data[owner*DW +: DW];
    assign last    = wrreq && (beat_cnt == LAST_BEAT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_vld) state_nxt = BURST;
            BURST:   if (!req[owner] || last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wrclk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            word_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (wrreq) begin
                beat_cnt <= beat_cnt + BW'(1);
                word_cnt <= word_cnt + CW'(1);
            end
            if (state == IDLE && sel_vld) begin
                owner    <= sel_idx;
                grant    <= NREQ'(1) << sel_idx;
                busy     <= 1'b1;
                beat_cnt <= '0;
            end
            // Leaving BURST: next search starts just past the finished owner.
            if (state == BURST && state_nxt == IDLE) begin
                rr_ptr <= (owner == LAST_REQ) ? '0 : owner + PW'(1);
                grant  <= '0;
                busy   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic        wrclk = 1'b0;
    logic        rst   = 1'b1;
    logic [3:0]  req   = '0;
    logic [31:0] req_data = '0;
    logic        full  = 1'b0;

    logic [3:0]  ack, grant;
    logic        wrreq, busy;
    logic [7:0]  data_in;
    logic [15:0] word_cnt;

    logic [3:0]  ack4, grant4;
    logic        wrreq4, busy4;
    logic [7:0]  data_in4;
    logic [3:0]  word_cnt4;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    always #5 wrclk = ~wrclk;

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4), .CW(16)) dut (
        .wrclk(wrclk), .rst(rst), .req(req), .req_data(req_data), .full(full),
        .ack(ack), .grant(grant), .wrreq(wrreq), .data_in(data_in),
        .busy(busy), .word_cnt(word_cnt)
    );

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4), .CW(4)) dut4 (
        .wrclk(wrclk), .rst(rst), .req(req), .req_data(req_data), .full(full),
        .ack(ack4), .grant(grant4), .wrreq(wrreq4), .data_in(data_in4),
        .busy(busy4), .word_cnt(word_cnt4)
    );

    // Invariants sampled mid-cycle on every cycle once enabled.
    always @(negedge wrclk) begin
        if (mon_en) begin
            n_cmp++;
            if ((wrreq & full) !== 1'b0 || (wrreq4 & full) !== 1'b0) begin
                n_bad++;
                $display("FAIL inv_wrreq_full: wrreq=%b wrreq4=%b full=%b, required never both 1", wrreq, wrreq4, full);
            end
            n_cmp++;
            if (!$onehot0(ack) || !$onehot0(grant) || ((ack & ~grant) !== 4'b0)) begin
                n_bad++;
                $display("FAIL inv_onehot: ack=%b grant=%b, required onehot0 and ack within grant", ack, grant);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge wrclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; full = 1'b0; req_data = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; full = 1'b0;
        @(negedge wrclk);
        n_cmp++;
        if (ack !== 4'b0 || wrreq !== 1'b0) begin
            n_bad++; $display("FAIL reset_ack: ack=%b wrreq=%b, required 0000/0", ack, wrreq);
        end
        cyc();
        @(negedge wrclk);
        n_cmp++;
        if (grant !== 4'b0 || busy !== 1'b0 || word_cnt !== 16'd0 || word_cnt4 !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_state: grant=%b busy=%b word_cnt=%0d word_cnt4=%0d, required 0/0/0/0", grant, busy, word_cnt, word_cnt4);
        end
        req = '0;
    endtask

    task automatic test_single();
        logic [10:0] exp_w;
        int k;
        do_reset();
        exp_w = 11'b01111011110;
        k = 0;
        for (int c = 0; c < 11; c++) begin
            req = (k < 8) ? 4'b0001 : 4'b0000;
            req_data = {24'h0, 8'h10 + 8'(k)};
            @(negedge wrclk);
            n_cmp++;
            if (wrreq !== exp_w[c]) begin
                n_bad++; $display("FAIL single_wrreq c%0d: wrreq=%b, required %b", c, wrreq, exp_w[c]);
            end
            if (ack[0] === 1'b1) begin
                n_cmp++;
                if (data_in !== 8'h10 + 8'(k)) begin
                    n_bad++; $display("FAIL single_data: data_in=%h, required %h", data_in, 8'h10 + 8'(k));
                end
                k++;
            end
            cyc();
        end
        @(negedge wrclk);
        n_cmp++;
        if (k != 8 || word_cnt !== 16'd8) begin
            n_bad++; $display("FAIL single_count: words=%0d word_cnt=%0d, required 8/8", k, word_cnt);
        end
        req = '0;
    endtask

    task automatic test_all();
        int cnt[4];
        int n_w;
        logic [3:0] exp_g;
        do_reset();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        n_w = 0;
        req = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(i*16 + cnt[i]);
            @(negedge wrclk);
            if (c % 5 == 1) begin
                exp_g = 4'b0001 << ((c / 5) % 4);
                n_cmp++;
                if (grant !== exp_g) begin
                    n_bad++; $display("FAIL all_grant c%0d: grant=%b, required %b", c, grant, exp_g);
                end
            end
            if (c % 5 == 0) begin
                n_cmp++;
                if (wrreq !== 1'b0) begin
                    n_bad++; $display("FAIL all_bubble c%0d: wrreq=%b, required 0", c, wrreq);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (ack[i] === 1'b1) begin
                    n_cmp++;
                    if (data_in !== 8'(i*16 + cnt[i])) begin
                        n_bad++; $display("FAIL all_data req%0d: data_in=%h, required %h", i, data_in, 8'(i*16 + cnt[i]));
                    end
                    cnt[i]++;
                end
            end
            if (wrreq === 1'b1) n_w++;
            cyc();
        end
        req = '0;
        @(negedge wrclk);
        n_cmp++;
        if (n_w != 20 || cnt[0] != 8 || cnt[1] != 4 || cnt[2] != 4 || cnt[3] != 4 || word_cnt !== 16'd20) begin
            n_bad++;
            $display("FAIL all_totals: writes=%0d per-req=%0d,%0d,%0d,%0d word_cnt=%0d, required 20 8,4,4,4 20", n_w, cnt[0], cnt[1], cnt[2], cnt[3], word_cnt);
        end
    endtask

    task automatic test_full_stall();
        int k;
        do_reset();
        k = 0;
        for (int c = 0; c < 11; c++) begin
            full = (c >= 3 && c <= 7);
            req  = (k < 4) ? 4'b0100 : 4'b0000;
            req_data = {8'h00, 8'h20 + 8'(k), 16'h0000};
            @(negedge wrclk);
            if (full) begin
                n_cmp++;
                if (ack !== 4'b0 || wrreq !== 1'b0 || grant !== 4'b0100 || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stall c%0d: ack=%b wrreq=%b grant=%b busy=%b, required 0000/0/0100/1", c, ack, wrreq, grant, busy);
                end
            end
            if (c == 8) begin
                n_cmp++;
                if (wrreq !== 1'b1) begin
                    n_bad++; $display("FAIL stall_resume: wrreq=%b, required 1", wrreq);
                end
            end
            if (c == 10) begin
                n_cmp++;
                if (grant !== 4'b0 || busy !== 1'b0) begin
                    n_bad++; $display("FAIL stall_end: grant=%b busy=%b, required 0000/0", grant, busy);
                end
            end
            if (ack[2] === 1'b1) begin
                n_cmp++;
                if (data_in !== 8'h20 + 8'(k)) begin
                    n_bad++; $display("FAIL stall_data: data_in=%h, required %h", data_in, 8'h20 + 8'(k));
                end
                k++;
            end
            cyc();
        end
        full = 1'b0;
        req  = '0;
        @(negedge wrclk);
        n_cmp++;
        if (k != 4 || word_cnt !== 16'd4) begin
            n_bad++; $display("FAIL stall_count: words=%0d word_cnt=%0d, required 4/4", k, word_cnt);
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req_data = 32'h00005100;
        for (int c = 0; c < 6; c++) begin
            req = (c <= 2) ? 4'b1010 : (c == 3) ? 4'b1000 : 4'b1001;
            @(negedge wrclk);
            if (c == 1 || c == 2) begin
                n_cmp++;
                if (ack !== 4'b0010) begin
                    n_bad++; $display("FAIL early_ack c%0d: ack=%b, required 0010", c, ack);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if (ack !== 4'b0 || wrreq !== 1'b0 || grant !== 4'b0010) begin
                    n_bad++; $display("FAIL early_drop: ack=%b wrreq=%b grant=%b, required 0000/0/0010", ack, wrreq, grant);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (grant !== 4'b0 || busy !== 1'b0) begin
                    n_bad++; $display("FAIL early_idle: grant=%b busy=%b, required 0000/0", grant, busy);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (grant !== 4'b1000 || busy !== 1'b1 || ack !== 4'b1000) begin
                    n_bad++; $display("FAIL early_next: grant=%b busy=%b ack=%b, required 1000/1/1000", grant, busy, ack);
                end
            end
            cyc();
        end
        req = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_data = 32'h00000000;
        for (int c = 0; c < 11; c++) begin
            rst = (c == 8);
            req = (c <= 4) ? 4'b0010 : (c <= 8) ? 4'b0001 : 4'b0101;
            @(negedge wrclk);
            if (c == 7) begin
                n_cmp++;
                if (ack !== 4'b0001) begin
                    n_bad++; $display("FAIL rstmid_pre: ack=%b, required 0001", ack);
                end
            end
            if (c == 8) begin
                n_cmp++;
                if (ack !== 4'b0 || wrreq !== 1'b0 || word_cnt !== 16'd6) begin
                    n_bad++; $display("FAIL rstmid_cycle: ack=%b wrreq=%b word_cnt=%0d, required 0000/0/6", ack, wrreq, word_cnt);
                end
            end
            if (c == 9) begin
                n_cmp++;
                if (grant !== 4'b0 || busy !== 1'b0 || word_cnt !== 16'd0) begin
                    n_bad++; $display("FAIL rstmid_after: grant=%b busy=%b word_cnt=%0d, required 0000/0/0", grant, busy, word_cnt);
                end
            end
            if (c == 10) begin
                n_cmp++;
                if (grant !== 4'b0001) begin
                    n_bad++; $display("FAIL rstmid_rrptr: grant=%b, required 0001", grant);
                end
            end
            cyc();
        end
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_counter_wrap();
        int exp_cnt;
        int c;
        do_reset();
        req = 4'b0001;
        exp_cnt = 0;
        c = 0;
        while (exp_cnt < 17 && c < 300) begin
            full = 1'($urandom_range(0, 1));
            @(negedge wrclk);
            n_cmp++;
            if (word_cnt4 !== 4'(exp_cnt)) begin
                n_bad++; $display("FAIL wrap_cnt: word_cnt=%0d, required %0d", word_cnt4, 4'(exp_cnt));
            end
            if (ack4[0] === 1'b1) exp_cnt++;
            cyc();
            c++;
        end
        full = 1'b0;
        req  = '0;
        @(negedge wrclk);
        n_cmp++;
        if (c >= 300 || word_cnt4 !== 4'd1 || word_cnt !== 16'd17) begin
            n_bad++;
            $display("FAIL wrap_final: cycles=%0d word_cnt4=%0d word_cnt=%0d, required <300/1/17", c, word_cnt4, word_cnt);
        end
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_single();
        test_all();
        test_full_stall();
        test_early_release();
        test_reset_mid_burst();
        test_counter_wrap();
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the single FIFO write port among NREQ requesters, all in the write clock domain.
- Grants one requester a burst of up to MAX_BURST words and forwards that requester's data to the FIFO.
- Drives the FIFO write request and write data; honours the FIFO full flag so no write is ever lost or issued while full.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width; matches FIFO data_in.
- MAX_BURST, 4, maximum words per grant (1..16).
- CW, 16, width of the accepted-word counter.

Ports:
- wrclk  input  1  write-domain clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester write request; held while data is valid.
- req_data  input  NREQ*DW  packed requester data; slice i is bits [i*DW +: DW].
- full  input  1  FIFO full flag (write domain).
- ack  output  NREQ  one-hot, combinational; word from requester i accepted this cycle.
- grant  output  NREQ  one-hot registered current owner; 0 when idle.
- wrreq  output  1  FIFO write strobe, combinational, equals OR of ack.
- data_in  output  DW  FIFO write data = req_data slice of owner.
- busy  output  1  registered; high in BURST state.
- word_cnt  output  CW  registered count of accepted words, wraps modulo 2^CW.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0;
  - grant=0, busy=0, word_cnt=0.
- During any cycle with rst=1, ack=0 and wrreq=0. This holds even mid-burst, and the in-flight word is not written.
- States: IDLE, BURST.
- IDLE:
  - ack=0, wrreq=0.
  - If any req is high, select the first requester with req=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - Next edge: state=BURST, owner=selected, grant=onehot(owner), busy=1, beat_cnt=0.
  - Arbitration costs exactly one bubble cycle per burst.
- BURST:
  - ack[owner] = req[owner] & ~full & ~rst. All other ack bits are 0.
  - wrreq = |ack. data_in = req_data[owner] regardless of ack (don't-care when wrreq=0).
  - On ack: beat_cnt increments and word_cnt increments (wrapping).
  - full=1 stalls the burst; the grant is kept and no beat is counted. A requester must hold req and data stable until acked.
- BURST exits to IDLE on the next edge when either:
  - (a) req[owner]=0 in a cycle (no ack that cycle); or
  - (b) ack occurs with beat_cnt==MAX_BURST-1 (last beat).
- On exit: rr_ptr=(owner+1) mod NREQ, grant=0, busy=0.
- Fairness: the same requester cannot be re-granted while another requester is pending. Worst-case wait is (NREQ-1)*(MAX_BURST+1) cycles plus full-stall time.
- Requests from non-owners during BURST are ignored; they are sampled again in IDLE.
- Simultaneous last beat and full=1: no ack, so the burst does not end; the last beat completes when full drops.
- MAX_BURST=1: every grant is one word followed by an IDLE cycle.
- Widths:
  - beat_cnt is $clog2(MAX_BURST+1) bits; rr_ptr and owner are $clog2(NREQ) bits.
  - For NREQ not a power of two, the wrap is explicit compare-to-NREQ-1, not bit truncation.
- Invariants the bench checks:
  - wrreq & full never both 1.
  - ack and grant always zero or one-hot.
  - ack ⊆ grant.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state enum {IDLE, BURST};
  - default constants for NREQ, DW, MAX_BURST, CW;
  - a function rr_pick(req, rr_ptr) returning the index and a valid flag.
- One sub-module, rr_select: a combinational rotate/priority-encode that finds the first set bit at or after rr_ptr. It is reusable by the read-side scheduler.
- FSM, counters and the data mux stay in fifo_wr_arbiter.

Test Plan:
- Single requester: req=4'b0001, data 8'h10..8'h17 over 8 words, full=0.
  - Expect two bursts of 4 words, wrreq low for 1 idle cycle between them.
  - FIFO receives 10..17 in order; word_cnt=8.
- All requesters: req=4'b1111 held, each with a distinct data pattern, full=0.
  - Expect grant order 0,1,2,3,0 and 4 words per grant.
  - 20 wrreq in 25 cycles.
- Full stall: requester 2 in BURST after 2 beats, full=1 for 5 cycles, then 0.
  - Expect ack=0 and wrreq=0 for 5 cycles, grant stays 4'b0100.
  - Remaining 2 words are written after full drops; no word is duplicated or dropped.
- Early release: requester 1 drops req after 2 accepted words while req[3]=1.
  - Expect BURST→IDLE, then grant=4'b1000 on the second edge.
  - rr_ptr=2 at the time of that selection.
- Reset mid-burst: rst=1 for one cycle during beat 2 of requester 0.
  - Expect ack=0 and wrreq=0 that cycle, then grant=0, busy=0, word_cnt=0.
  - Next arbitration starts from requester 0.
- Counter wrap: CW=4, 17 words accepted.
  - Expect word_cnt sequence ...,15,0,1.
  - Assertion wrreq&full==0 holds across random full toggling.
